// File: rtl/matrix_tile_pkg.sv
// Shared types and constants for the matrix tile buffer RAM.
// Optional MATRIX_TILE_RAM_BYPASS_EN selects write-first collisions in matrix_tile_ram.
package matrix_tile_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } tile_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // wr_count must be able to hold DEPTH itself, which can equal 2**ADDR_W.
  function automatic int count_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/matrix_tile_ram_core.sv
// Bare storage array (no reset) with one write port and one registered read port.
module tile_ram_core #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // Callers only assert we/re for in-range addresses, so the upper bits can be dropped.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[IDX_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr[IDX_W-1:0]];
  end

endmodule

// File: rtl/matrix_tile_ram.sv
// Dual-port tile buffer: write port A, read port B, clear engine, oob flag, write counter.
// Define MATRIX_TILE_RAM_BYPASS_EN for write-first same-address collisions (default read-first).
module matrix_tile_ram
  import matrix_tile_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              clear_req,
  output logic              busy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              oob_err,
  output logic [ADDR_W:0]   wr_count
);

  localparam int CNT_W = count_width(ADDR_W);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("matrix_tile_ram: RD_LAT must be 1 or 2");
    end
    if ((2 ** ADDR_W) < DEPTH || DEPTH < 2) begin : g_bad_depth
      $error("matrix_tile_ram: need DEPTH >= 2 and 2**ADDR_W >= DEPTH");
    end
  endgenerate

  tile_state_e       state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              sweeping;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sweeping  = 1'b0;
    case (state)
      ST_INIT, ST_CLEAR: begin
        sweeping = 1'b1;
        if (ptr == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Handshake: a transfer happens on a port in any cycle where valid && ready.
  // ready depends only on the registered state, never on valid.
  logic idle;
  assign idle    = (state == ST_IDLE);
  assign a_ready = idle;
  assign b_ready = idle;
  assign busy    = ~idle;

  logic a_fire, b_fire, a_in, b_in, a_wr, b_rd, collide, clear_go;
  assign a_fire   = a_valid & idle;
  assign b_fire   = b_valid & idle;
  assign a_in     = {1'b0, a_addr} < DEPTH_C;
  assign b_in     = {1'b0, b_addr} < DEPTH_C;
  assign a_wr     = a_fire & a_in;
  assign b_rd     = b_fire & b_in;
  assign clear_go = idle & clear_req;

`ifdef MATRIX_TILE_RAM_BYPASS_EN
  assign collide = a_wr & b_rd & (a_addr == b_addr);
`else
  assign collide = 1'b0;
`endif

  logic [DATA_W-1:0] core_rdata;

  tile_ram_core #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk  (sys_clk),
    .rst_n(sys_rst_n),
    .we   (sweeping | a_wr),
    .waddr(sweeping ? ptr : a_addr),
    .wdata(sweeping ? '0 : a_wdata),
    .re   (b_rd),
    .raddr(b_addr),
    .rdata(core_rdata)
  );

  // Stage-1 side info only changes on acceptance, so the muxed data holds between pulses.
  logic              r1_valid, r1_oob, r1_byp;
  logic [DATA_W-1:0] r1_wdata, r1_data;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r1_valid <= 1'b0;
      r1_oob   <= 1'b0;
      r1_byp   <= 1'b0;
      r1_wdata <= '0;
    end else begin
      r1_valid <= b_fire;
      if (b_fire) begin
        r1_oob   <= ~b_in;
        r1_byp   <= collide;
        r1_wdata <= a_wdata;
      end
    end
  end

  assign r1_data = r1_oob ? '0 : (r1_byp ? r1_wdata : core_rdata);

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r2_valid;
      logic [DATA_W-1:0] r2_data;
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r2_valid <= 1'b0;
          r2_data  <= '0;
        end else begin
          r2_valid <= r1_valid;
          if (r1_valid) r2_data <= r1_data;
        end
      end
      assign b_rvalid = r2_valid;
      assign b_rdata  = r2_data;
    end else begin : g_lat1
      assign b_rvalid = r1_valid;
      assign b_rdata  = r1_data;
    end
  endgenerate

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt     <= '0;
      oob_err <= 1'b0;
    end else if (clear_go) begin
      cnt     <= '0;
      oob_err <= 1'b0;
    end else begin
      if (a_wr && cnt != DEPTH_C) cnt <= cnt + 1'b1;
      if ((a_fire && !a_in) || (b_fire && !b_in)) oob_err <= 1'b1;
    end
  end

  assign wr_count = cnt;

endmodule

// File: tb/tb_matrix_tile_ram.sv
// Scoreboard bench for matrix_tile_ram: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream.
module tb_matrix_tile_ram;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 5;

`ifdef MATRIX_TILE_RAM_BYPASS_EN
  localparam logic [DW-1:0] COLL_EXP = 16'hBEEF;
`else
  localparam logic [DW-1:0] COLL_EXP = 16'h0001;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          clear_req = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0;

  logic          busy1, a_ready1, b_ready1, rvalid1, oob1;
  logic [DW-1:0] rdata1;
  logic [AW:0]   cnt1;
  logic          busy2, a_ready2, b_ready2, rvalid2, oob2;
  logic [DW-1:0] rdata2;
  logic [AW:0]   cnt2;

  matrix_tile_ram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(1)) u_lat1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
    .a_valid(a_valid), .a_ready(a_ready1), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready1), .b_addr(b_addr),
    .b_rvalid(rvalid1), .b_rdata(rdata1), .oob_err(oob1), .wr_count(cnt1)
  );

  matrix_tile_ram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(2)) u_lat2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .clear_req(clear_req), .busy(busy2),
    .a_valid(a_valid), .a_ready(a_ready2), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready2), .b_addr(b_addr),
    .b_rvalid(rvalid2), .b_rdata(rdata2), .oob_err(oob2), .wr_count(cnt2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp1_q[$], exp2_q[$];
  int            acc1_q[$], acc2_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [DW-1:0] e1, e2;
  int            a1, a2;

  always @(negedge clk) begin
    if (rvalid1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL lat1_unexpected_rvalid: got rvalid with data 0x%0h, expected none (t=%0t)", rdata1, $time);
      end else begin
        e1 = exp1_q.pop_front();
        a1 = acc1_q.pop_front();
        check("lat1_rdata", rdata1, e1);
        check("lat1_latency", cyc - a1, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid2 === 1'b1) begin
      if (exp2_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL lat2_unexpected_rvalid: got rvalid with data 0x%0h, expected none (t=%0t)", rdata2, $time);
      end else begin
        e2 = exp2_q.pop_front();
        a2 = acc2_q.pop_front();
        check("lat2_rdata", rdata2, e2);
        check("lat2_latency", cyc - a2, 2);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bexp,
                       input logic clr);
    int acc;
    a_valid   = av;
    a_addr    = aa;
    a_wdata   = ad;
    b_valid   = bv;
    b_addr    = ba;
    clear_req = clr;
    acc       = cyc;
    @(posedge clk);
    #1;
    if (bv) begin
      exp1_q.push_back(bexp);
      acc1_q.push_back(acc);
      exp2_q.push_back(bexp);
      acc2_q.push_back(acc);
    end
    a_valid   = 1'b0;
    b_valid   = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    issue(1'b1, aa, ad, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] ba, input logic [DW-1:0] bexp);
    issue(1'b0, '0, '0, 1'b1, ba, bexp, 1'b0);
  endtask

  // Counts cycles with busy high, starting from the current (busy) cycle; bounded.
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy1, 1);
    check("rst_a_ready", a_ready1, 0);
    check("rst_b_ready", b_ready2, 0);
    check("rst_rvalid", {rvalid1, rvalid2}, 0);
    check("rst_rdata", {rdata1, rdata2}, 0);
    check("rst_oob", {oob1, oob2}, 0);
    check("rst_wr_count", cnt1, 0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep(n);
    check("init_len", n, 16);
    check("init_ready", {a_ready1, b_ready1, a_ready2, b_ready2, busy2}, 5'b11110);

    for (int i = 0; i < DEPTH; i++) rd(AW'(i), '0);

    wr(5'd5, 16'h1234);
    rd(5'd5, 16'h1234);

    wr(5'd7, 16'h0001);
    issue(1'b1, 5'd7, 16'hBEEF, 1'b1, 5'd7, COLL_EXP, 1'b0);
    rd(5'd7, 16'hBEEF);
    check("wr_count_3", cnt1, 3);
    check("wr_count_3_lat2", cnt2, 3);

    wr(5'd20, 16'h7777);
    check("oob_wr_count", cnt1, 3);
    check("oob_set", {oob1, oob2}, 2'b11);
    rd(5'd20, '0);

    // Clear with a same-cycle write, then hold both valids high through the sweep.
    issue(1'b1, 5'd9, 16'h5555, 1'b0, '0, '0, 1'b1);
    check("clear_oob", {oob1, oob2}, 0);
    check("clear_wr_count", cnt1, 0);
    a_valid = 1'b1;
    a_addr  = 5'd3;
    a_wdata = 16'hAAAA;
    b_valid = 1'b1;
    b_addr  = 5'd3;
    wait_sweep(n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("clear_len", n, 16);
    check("sweep_no_accept", cnt1, 0);
    rd(5'd3, '0);
    rd(5'd9, '0);
    rd(5'd5, '0);

    for (int i = 0; i < 17; i++) wr(AW'(i % DEPTH), DW'(i + 1));
    check("wr_count_sat", cnt1, 16);
    check("wr_count_sat_lat2", cnt2, 16);
    rd(5'd15, 16'h0010);
    rd(5'd0, 16'h0011);

    issue(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    check("clear2_wr_count", cnt1, 0);
    wait_sweep(n);
    check("clear2_len", n, 16);

    // Reset in the eighth cycle of a CLEAR sweep.
    issue(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    check("mid_clear_busy", busy1, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_clear_rst_ready", {a_ready1, b_ready2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep(n);
    check("reinit_len", n, 16);

    // Reset right after a read acceptance: the pending response must vanish.
    wr(5'd5, 16'h5A5A);
    b_valid = 1'b1;
    b_addr  = 5'd5;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rd_rst_state", {busy1, a_ready1, rvalid1, rvalid2, oob1}, 5'b10000);
    check("rd_rst_rdata", rdata2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep(n);
    check("reinit2_len", n, 16);
    rd(5'd5, '0);

    repeat (4) @(posedge clk);
    #1;
    check("q1_drained", exp1_q.size(), 0);
    check("q2_drained", exp2_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
